// File: rtl/afifo_pkte.sv
// Shared types and constants for the async FIFO and its read-side drain logic.
package afifo_pkte;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned RDBUF_DEPTH = 2;
  localparam int unsigned OCC_W       = $clog2(RDBUF_DEPTH + 1);

  typedef logic [DATA_W-1:0] data_ty;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } rdbuf_state_e;

  function automatic logic [OCC_W-1:0] occ_of(input rdbuf_state_e s);
    case (s)
      S1:      return OCC_W'(1);
      S2:      return OCC_W'(2);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/afifo_skid2.sv
// Two-entry ordered output buffer: one write port, valid/ready read port,
// occupancy tracked as an FSM with registered valid/occ outputs.
module afifo_skid2
  import afifo_pkte::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [OCC_W-1:0] o_occ
);

  rdbuf_state_e     r_state;
  rdbuf_state_e     w_next;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             r_valid;
  logic [OCC_W-1:0] r_occ;
  logic             w_fire;

  assign w_fire  = r_valid & i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_head;
  assign o_occ   = r_occ;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S0:      if (i_wr_en) w_next = S1;
      S1: begin
        if (i_wr_en && !w_fire)      w_next = S2;
        else if (!i_wr_en && w_fire) w_next = S0;
      end
      S2:      if (w_fire) w_next = S1;
      default: w_next = S0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S0;
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= 1'b0;
      r_occ   <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next != S0);
      r_occ   <= occ_of(w_next);
      case (r_state)
        S0: if (i_wr_en) r_head <= i_wr_data;
        S1: begin
          // write+fire in S1 replaces the head; write alone lands behind it
          if (i_wr_en && w_fire) r_head <= i_wr_data;
          else if (i_wr_en)      r_tail <= i_wr_data;
        end
        S2: if (w_fire) r_head <= r_tail;
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_state == S2 && i_wr_en && !w_fire));

endmodule

// File: rtl/afifo_rd_drain.sv
// Read-side FIFO consumer: credit-limited pop issue, one-cycle-latency capture
// into a 2-entry buffer, and a wrapping pop counter.
module afifo_rd_drain
  import afifo_pkte::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_rd,
  input  logic             rd_rst,
  input  logic             en,
  input  logic             empty,
  output logic             pop,
  input  logic [WIDTH-1:0] fifo_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] pop_cnt,
  output logic             busy
);

  logic             r_inflight;
  logic [CNT_W-1:0] r_pop_cnt;
  logic [OCC_W-1:0] w_occ;
  logic [OCC_W-1:0] w_need;
  logic [OCC_W-1:0] w_budget;
  logic             w_fire;

  assign w_fire   = m_valid & m_ready;
  assign w_need   = w_occ + OCC_W'(r_inflight);
  assign w_budget = OCC_W'(1) + OCC_W'(w_fire);
  // rd_rst term keeps the strobe quiet while reset is held
  assign pop      = rd_rst & en & ~empty & (w_need <= w_budget);
  assign busy     = (w_occ != '0) | r_inflight;
  assign pop_cnt  = r_pop_cnt;

  afifo_skid2 #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk_rd),
    .rst_n     (rd_rst),
    .i_wr_en   (r_inflight),
    .i_wr_data (fifo_data),
    .o_valid   (m_valid),
    .i_ready   (m_ready),
    .o_data    (m_data),
    .o_occ     (w_occ)
  );

  always_ff @(posedge clk_rd or negedge rd_rst) begin
    if (!rd_rst) begin
      r_inflight <= 1'b0;
      r_pop_cnt  <= '0;
    end else begin
      r_inflight <= pop;
      if (pop) r_pop_cnt <= r_pop_cnt + CNT_W'(1);
    end
  end

  a_no_pop_empty: assert property (@(posedge clk_rd) disable iff (!rd_rst)
    pop |-> !empty);
  a_occ_bound: assert property (@(posedge clk_rd) disable iff (!rd_rst)
    w_occ <= OCC_W'(RDBUF_DEPTH));
  a_stall_stable: assert property (@(posedge clk_rd) disable iff (!rd_rst)
    (m_valid && !m_ready) |=> $stable(m_data));

endmodule
